bus_arbiter2: RTL

BUS_ARBITER2 -- requirements
Module: bus_arbiter2

---
 rtl/bus_pkg.sv | 23 ++
 rtl/bus_addr_dec.sv | 16 +
 rtl/bus_arbiter2.sv | 101 ++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding and
// the slave address map expressed as match/mask pairs.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  // A slave is hit when (addr & MASK) == MATCH.
  localparam logic [15:0] S0_MATCH = 16'h0000;
  localparam logic [15:0] S0_MASK  = 16'hF800;
  localparam logic [15:0] S1_MATCH = 16'h7000;
  localparam logic [15:0] S1_MASK  = 16'hFE00;

  function automatic logic addr_hit(input logic [15:0] addr,
                                    input logic [15:0] match,
                                    input logic [15:0] mask);
    return (addr & mask) == match;
  endfunction

endpackage

// File: rtl/bus_addr_dec.sv
// Combinational slave decoder; selects are forced low while no master owns the bus.
module bus_addr_dec
  import bus_pkg::*;
(
  input  logic        enable,
  input  logic [15:0] addr,
  output logic        s0_sel,
  output logic        s1_sel
);

  always_comb begin
    s0_sel = enable && addr_hit(addr, S0_MATCH, S0_MASK);
    s1_sel = enable && addr_hit(addr, S1_MATCH, S1_MASK);
  end

endmodule

// File: rtl/bus_arbiter2.sv
// Two-master, two-slave bus arbiter: non-preemptive FSM with master 0 priority
// from IDLE, shared slave-side mux, and one-cycle registered read-data return.
module bus_arbiter2
  import bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [15:0] m0_addr,
  input  logic [63:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [15:0] m1_addr,
  input  logic [63:0] m1_dout,
  input  logic [63:0] s0_dout,
  input  logic [63:0] s1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [63:0] m_din,
  output logic        s0_sel,
  output logic        s1_sel,
  output logic        s_wr,
  output logic [15:0] s_addr,
  output logic [63:0] s_din
);

  state_t      state;
  state_t      next_state;
  logic [1:0]  rd_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rd_sel <= 2'b00;
    end else begin
      state  <= next_state;
      rd_sel <= {s0_sel, s1_sel};
    end
  end

  // The current owner keeps the bus while it requests; otherwise hand over
  // directly to the other requester, with master 0 winning ties from IDLE.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE: begin
        if (m0_req)      next_state = GNT0;
        else if (m1_req) next_state = GNT1;
      end
      GNT0: begin
        if (m0_req)      next_state = GNT0;
        else if (m1_req) next_state = GNT1;
      end
      GNT1: begin
        if (m1_req)      next_state = GNT1;
        else if (m0_req) next_state = GNT0;
      end
      default:           next_state = IDLE;
    endcase
  end

  always_comb begin
    m0_grant = (state == GNT0);
    m1_grant = (state == GNT1);
    s_wr     = 1'b0;
    s_addr   = 16'h0000;
    s_din    = 64'h0;
    case (state)
      GNT0: begin
        s_wr   = m0_wr;
        s_addr = m0_addr;
        s_din  = m0_dout;
      end
      GNT1: begin
        s_wr   = m1_wr;
        s_addr = m1_addr;
        s_din  = m1_dout;
      end
      default: ;
    endcase
  end

  bus_addr_dec u_dec (
    .enable (state != IDLE),
    .addr   (s_addr),
    .s0_sel (s0_sel),
    .s1_sel (s1_sel)
  );

  // rd_sel reflects the previous cycle's decode, so a handover cycle still
  // returns the old owner's read data.
  always_comb begin
    case (rd_sel)
      2'b10:   m_din = s0_dout;
      2'b01:   m_din = s1_dout;
      default: m_din = 64'h0;
    endcase
  end

endmodule
